// File: rtl/byte_serial_adder_pkg.sv
// ============================================================================
// Module      : byte_serial_adder_pkg
// Description : Shared constants and FSM state encoding for byte_serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package byte_serial_adder_pkg;

    localparam int SLICE_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/byte_serial_adder_cla8_slice.sv
// ============================================================================
// Module      : cla8_slice
// Description : 8-bit combinational carry-lookahead adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;
    logic       w_term;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is a flat sum of products of g/p terms, not a ripple chain.
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            w_term = cin;
            for (int k = 0; k <= i; k++) begin
                w_term = w_term & w_p[k];
            end
            w_c[i+1] = w_term;
            for (int j = 0; j <= i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_c[i+1] = w_c[i+1] | w_term;
            end
        end
    end

    assign s    = w_p ^ w_c[7:0];
    assign cout = w_c[8];

endmodule

`default_nettype wire

// File: rtl/byte_serial_adder.sv
// ============================================================================
// Module      : byte_serial_adder
// Description : Multi-byte adder processing one 8-bit slice per clock, LSB
//               first. Define BSA_OVERFLOW_EN to add the signed ovf output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SLICE_W*NBYTES-1:0] a,
    input  logic [SLICE_W*NBYTES-1:0] b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [SLICE_W*NBYTES-1:0] s,
    output logic                      cout
`ifdef BSA_OVERFLOW_EN
    ,
    output logic                      ovf
`endif
);

    localparam int c_width = SLICE_W * NBYTES;
    localparam int c_idx_w = $clog2(NBYTES) + 1;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_width-1:0] r_a;
    logic [c_width-1:0] r_b;
    logic [c_width-1:0] r_s;
    logic               r_carry;
    logic               r_cout;
    logic [c_idx_w-1:0] r_idx;

    logic [SLICE_W-1:0] w_a_byte;
    logic [SLICE_W-1:0] w_b_byte;
    logic [SLICE_W-1:0] w_sum_byte;
    logic               w_slice_cout;
    logic               w_last;

    assign w_a_byte = SLICE_W'(r_a >> (SLICE_W * r_idx));
    assign w_b_byte = SLICE_W'(r_b >> (SLICE_W * r_idx));
    assign w_last   = (r_idx == c_idx_w'(NBYTES - 1));

    cla8_slice u_slice (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .cin  (r_carry),
        .s    (w_sum_byte),
        .cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_s     <= '0;
                        r_cout  <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (r_idx == c_idx_w'(i)) begin
                            r_s[i*SLICE_W +: SLICE_W] <= w_sum_byte;
                        end
                    end
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + c_idx_w'(1);
                    if (w_last) begin
                        r_cout <= w_slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = r_s;
    assign cout = r_cout;

`ifdef BSA_OVERFLOW_EN
    logic r_ovf;
    logic w_c_msb;

    // Carry into the top bit is recoverable from that bit's sum and operands.
    assign w_c_msb = w_a_byte[SLICE_W-1] ^ w_b_byte[SLICE_W-1] ^ w_sum_byte[SLICE_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= w_c_msb ^ w_slice_cout;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_byte_serial_adder.sv
// ============================================================================
// Module      : tb_byte_serial_adder
// Description : Directed self-checking bench for byte_serial_adder (NBYTES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_serial_adder;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
`ifdef BSA_OVERFLOW_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    byte_serial_adder #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef BSA_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done; returns cycles after E0.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, output int cyc);
        a = av; b = bv; cin = cv; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, done, cout} !== 3'b000 || s !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b cout=%b s=%h required 0", busy, done, cout, s);
        end
`ifdef BSA_OVERFLOW_EN
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b required 0", ovf); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cyc;
        do_op(32'h0000_0005, 32'h0000_0003, 1'b0, cyc);
        checks++;
        if (cyc !== 4) begin failures++; $display("FAIL basic_latency: got %0d required 4", cyc); end
        checks++;
        if (s !== 32'h0000_0008 || cout !== 1'b0) begin
            failures++; $display("FAIL basic_sum: got %b_%h required 0_00000008", cout, s);
        end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done: got %b required 1", busy); end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_done_pulse: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_carry_chain();
        int cyc;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, cyc);
        checks++;
        if (cyc !== 4 || s !== 32'h0000_0000 || cout !== 1'b1) begin
            failures++; $display("FAIL carry_chain: cyc=%0d got %b_%h required 4 1_00000000", cyc, cout, s);
        end
`ifdef BSA_OVERFLOW_EN
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL carry_chain_ovf: got %b required 0", ovf); end
`endif
        repeat (3) tick();
        checks++;
        if (s !== 32'h0000_0000 || cout !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL hold_idle: got %b_%h busy=%b required 1_00000000 busy=0", cout, s, busy);
        end
    endtask

    task automatic test_patterns();
        int cyc;
        do_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, cyc);
        checks++;
        if (s !== 32'h0000_0000 || cout !== 1'b1) begin
            failures++; $display("FAIL alternating: got %b_%h required 1_00000000", cout, s);
        end
        tick();
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, cyc);
        checks++;
        if (s !== 32'hACF1_3569 || cout !== 1'b0) begin
            failures++; $display("FAIL mixed: got %b_%h required 0_acf13569", cout, s);
        end
        tick();
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, cyc);
        checks++;
        if (s !== 32'hFFFF_FFFF || cout !== 1'b1) begin
            failures++; $display("FAIL max: got %b_%h required 1_ffffffff", cout, s);
        end
`ifdef BSA_OVERFLOW_EN
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL max_ovf: got %b required 0", ovf); end
`endif
        tick();
    endtask

    task automatic test_overflow();
        int cyc;
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, cyc);
        checks++;
        if (s !== 32'h8000_0000 || cout !== 1'b0) begin
            failures++; $display("FAIL overflow_sum: got %b_%h required 0_80000000", cout, s);
        end
`ifdef BSA_OVERFLOW_EN
        checks++;
        if (ovf !== 1'b1) begin failures++; $display("FAIL overflow_flag: got %b required 1", ovf); end
`endif
        tick();
    endtask

    task automatic test_start_during_run();
        int ndone;
        int cyc;
        ndone = 0;
        a = 32'h0000_0005; b = 32'h0000_0003; cin = 1'b0; start = 1'b1;
        tick();
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (i !== 4 || s !== 32'h0000_0008 || cout !== 1'b0) begin
                    failures++; $display("FAIL held_start_result: cyc=%0d got %b_%h required 4 0_00000008", i, cout, s);
                end
            end
        end
        checks++;
        if (ndone !== 1 || busy !== 1'b0) begin
            failures++; $display("FAIL held_start_single: dones=%0d busy=%b required 1 0", ndone, busy);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL held_start_reaccept: got busy=%b required 1", busy); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 4 || s !== 32'hFFFF_FFFE || cout !== 1'b1) begin
            failures++; $display("FAIL held_start_second: cyc=%0d got %b_%h required 4 1_fffffffe", cyc, cout, s);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        int cyc;
        ndone = 0;
        a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== '0 || cout !== 1'b0) begin
            failures++; $display("FAIL reset_mid_run: busy=%b done=%b s=%h cout=%b required 0 0 0 0", busy, done, s, cout);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin failures++; $display("FAIL reset_no_done: got %0d dones required 0", ndone); end
        do_op(32'h1111_1111, 32'h2222_2222, 1'b0, cyc);
        checks++;
        if (cyc !== 4 || s !== 32'h3333_3333 || cout !== 1'b0) begin
            failures++; $display("FAIL reset_restart: cyc=%0d got %b_%h required 4 0_33333333", cyc, cout, s);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_patterns();
        test_overflow();
        test_start_during_run();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
